// File: rtl/spi_master_pkg.sv
// Shared definitions for wb_spi_master: register map, bit positions, FSM encoding.
// Loopback support is compiled in by defining SPI_MASTER_LOOPBACK_EN.
package spi_master_pkg;

  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_DIV    = 2'd1;
  localparam logic [1:0] ADR_DATA   = 2'd2;
  localparam logic [1:0] ADR_STATUS = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_CPOL = 1;
  localparam int CTRL_CPHA = 2;
  localparam int CTRL_CS   = 3;
  localparam int CTRL_IE   = 4;
  localparam int CTRL_LOOP = 5;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVR  = 2;

  localparam int RST_DIV_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/spi_master_clk_div.sv
// SCLK timebase: free-running while a transfer is active, held at zero otherwise,
// emitting a one-cycle tick every DIV+1 clocks.
module spi_clk_div
  import spi_master_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = i_run && (r_cnt == i_div);
  assign o_tick = w_tick;

  // Clearing while idle means every transfer starts a full half-period from zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_run || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/wb_spi_master.sv
// Wishbone-slave SPI master: mode 0-3, 8-bit MSB-first, programmable divider, level IRQ.
// Define SPI_MASTER_LOOPBACK_EN to implement CTRL.LOOP (mosi fed back to the sampler).
module wb_spi_master
  import spi_master_pkg::*;
#(
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(RST_DIV_DEFAULT)
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_csb,
  input  logic        spi_miso
);

  state_t           r_state;
  state_t           w_state_n;
  logic             r_ack;
  logic [31:0]      r_dat;
  logic             r_irq;
  logic             r_en;
  logic             r_cpol;
  logic             r_cpha;
  logic             r_csb;
  logic             r_ie;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_rx;
  logic             r_done;
  logic             r_ovr;
  logic             r_lat_cpol;
  logic             r_lat_cpha;
  logic [DIV_W-1:0] r_lat_div;
  logic [3:0]       r_edge;
  logic [7:0]       r_shreg;
  logic             r_samp;
  logic             r_mosi;
  logic             r_sclk;

  logic        w_req;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_div;
  logic        w_wr_data;
  logic        w_wr_status;
  logic        w_busy;
  logic        w_start;
  logic        w_tick;
  logic        w_lead;
  logic        w_trail;
  logic        w_xfer_end;
  logic        w_miso;
  logic        w_loop_rd;
  logic        w_done_n;
  logic        w_ovr_n;
  logic        w_ie_n;
  logic [31:0] w_rd_data;
  logic        w_unused;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic r_loop;
  assign w_loop_rd = r_loop;
  assign w_miso    = r_loop ? r_mosi : spi_miso;
`else
  assign w_loop_rd = 1'b0;
  assign w_miso    = spi_miso;
`endif

  assign w_req       = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_wr        = w_req & wbs_we_i & wbs_sel_i[0];
  assign w_wr_ctrl   = w_wr && (wbs_adr_i[3:2] == ADR_CTRL);
  assign w_wr_div    = w_wr && (wbs_adr_i[3:2] == ADR_DIV);
  assign w_wr_data   = w_wr && (wbs_adr_i[3:2] == ADR_DATA);
  assign w_wr_status = w_wr && (wbs_adr_i[3:2] == ADR_STATUS);
  assign w_busy      = (r_state != S_IDLE);
  assign w_start     = w_wr_data && !w_busy && r_en;
  assign w_unused    = &{1'b0, wbs_sel_i[3:1], wbs_adr_i, wbs_dat_i};

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq_o     = r_irq;
  assign spi_sclk  = r_sclk;
  assign spi_mosi  = r_mosi;
  assign spi_csb   = r_csb;

  spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .i_clk  (wb_clk_i),
    .i_rst  (wb_rst_i),
    .i_run  (w_busy),
    .i_div  (r_lat_div),
    .o_tick (w_tick)
  );

  // FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next state and SCLK edge qualification; clearing EN aborts from any busy state.
  always_comb begin
    w_state_n  = r_state;
    w_lead     = 1'b0;
    w_trail    = 1'b0;
    w_xfer_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_n = S_SHIFT;
        else         w_state_n = S_IDLE;
      end
      S_SHIFT: begin
        if (!r_en) begin
          w_state_n = S_IDLE;
        end else if (w_tick) begin
          w_lead  = ~r_edge[0];
          w_trail = r_edge[0];
          if (r_edge == 4'd15) w_state_n = S_FINISH;
          else                 w_state_n = S_SHIFT;
        end else begin
          w_state_n = S_SHIFT;
        end
      end
      S_FINISH: begin
        if (!r_en) begin
          w_state_n = S_IDLE;
        end else if (w_tick) begin
          w_xfer_end = 1'b1;
          w_state_n  = S_IDLE;
        end else begin
          w_state_n = S_FINISH;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Read mux and next values of the sticky flags (completion wins over W1C).
  always_comb begin
    w_rd_data = 32'h0000_0000;
    case (wbs_adr_i[3:2])
      ADR_CTRL:   w_rd_data = {26'h0, w_loop_rd, r_ie, ~r_csb, r_cpha, r_cpol, r_en};
      ADR_DIV:    w_rd_data = 32'(r_div);
      ADR_DATA:   w_rd_data = {24'h0, r_rx};
      ADR_STATUS: w_rd_data = {29'h0, r_ovr, r_done, w_busy};
      default:    w_rd_data = 32'h0000_0000;
    endcase
    w_done_n = w_xfer_end | (r_done & ~(w_wr_status & wbs_dat_i[ST_DONE]));
    w_ovr_n  = (w_wr_data & w_busy) | (r_ovr & ~(w_wr_status & wbs_dat_i[ST_OVR]));
    if (w_wr_ctrl) w_ie_n = wbs_dat_i[CTRL_IE];
    else           w_ie_n = r_ie;
  end

  // Wishbone handshake, control registers and status flags.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack  <= 1'b0;
      r_dat  <= 32'h0000_0000;
      r_irq  <= 1'b0;
      r_en   <= 1'b0;
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
      r_csb  <= 1'b1;
      r_ie   <= 1'b0;
      r_div  <= RST_DIV;
      r_rx   <= 8'h00;
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
      r_loop <= 1'b0;
`endif
    end else begin
      r_ack  <= w_req;
      r_dat  <= (w_req && !wbs_we_i) ? w_rd_data : 32'h0000_0000;
      r_done <= w_done_n;
      r_ovr  <= w_ovr_n;
      r_ie   <= w_ie_n;
      r_irq  <= w_done_n & w_ie_n;
      if (w_wr_ctrl) begin
        r_en   <= wbs_dat_i[CTRL_EN];
        r_cpol <= wbs_dat_i[CTRL_CPOL];
        r_cpha <= wbs_dat_i[CTRL_CPHA];
        r_csb  <= ~wbs_dat_i[CTRL_CS];
`ifdef SPI_MASTER_LOOPBACK_EN
        r_loop <= wbs_dat_i[CTRL_LOOP];
`endif
      end
      if (w_wr_div) r_div <= wbs_dat_i[DIV_W-1:0];
      if (w_xfer_end) r_rx <= r_shreg;
    end
  end

  // Shift datapath: mode bits and divider are frozen at start so mid-transfer writes wait.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_lat_cpol <= 1'b0;
      r_lat_cpha <= 1'b0;
      r_lat_div  <= RST_DIV;
      r_edge     <= 4'd0;
      r_shreg    <= 8'h00;
      r_samp     <= 1'b0;
      r_mosi     <= 1'b0;
      r_sclk     <= 1'b0;
    end else begin
      if (w_start) begin
        r_lat_cpol <= r_cpol;
        r_lat_cpha <= r_cpha;
        r_lat_div  <= r_div;
        r_edge     <= 4'd0;
        r_shreg    <= wbs_dat_i[7:0];
        if (!r_cpha) r_mosi <= wbs_dat_i[7];
      end else if (w_lead) begin
        r_edge <= r_edge + 4'd1;
        if (r_lat_cpha) r_mosi <= r_shreg[7];
        else            r_samp <= w_miso;
      end else if (w_trail) begin
        r_edge <= r_edge + 4'd1;
        if (r_lat_cpha) begin
          r_shreg <= {r_shreg[6:0], w_miso};
        end else begin
          r_shreg <= {r_shreg[6:0], r_samp};
          r_mosi  <= r_shreg[6];
        end
      end

      if (w_lead || w_trail) begin
        r_sclk <= ~r_sclk;
      end else if (r_state == S_IDLE || w_state_n == S_IDLE) begin
        r_sclk <= r_cpol;
      end else if (r_state == S_FINISH) begin
        r_sclk <= r_lat_cpol;
      end else begin
        r_sclk <= r_sclk;
      end
    end
  end

endmodule
